// File: rtl/seg_display_scan.sv
// Scans a 32-bit value across an 8-digit multiplexed seven-segment display.
// Updates are double-buffered so a new value only appears at a frame boundary.
module seg_display_scan #(
    parameter int CLK_DIV      = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Load,
    input  logic [31:0] Data,
    input  logic        LZB,
    input  logic        Halt,
    output logic [7:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP,
    output logic        Frame
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [7:0] FC_MAX = 8'(BLINK_FRAMES - 1);

    logic [DIV_W-1:0] div;
    logic [2:0]       dig;
    logic [31:0]      pend;
    logic             pend_v;
    logic [31:0]      shown;
    logic [7:0]       fc;
    logic             phase;

    logic             tick;
    logic             wrap;
    logic [3:0]       nib;
    logic [7:0]       blank_mask;
    logic             blank;
    logic [7:0]       an_next;
    logic [6:0]       seg_next;
    logic             dp_next;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign tick = (div == DIV_MAX);
    assign wrap = tick && (dig == 3'd7);

    // Scan timing: divider and digit index
    always_ff @(posedge Clock) begin
        if (Reset) begin
            div <= '0;
            dig <= 3'd0;
        end else begin
            div <= tick ? '0 : div + 1'b1;
            if (tick) begin
                dig <= dig + 3'd1;
            end
        end
    end

    // A Load coinciding with a wrap still lets the older pending value through.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pend   <= 32'd0;
            pend_v <= 1'b0;
            shown  <= 32'd0;
        end else begin
            if (wrap && pend_v) begin
                shown <= pend;
            end
            if (Load) begin
                pend   <= Data;
                pend_v <= 1'b1;
            end else if (wrap) begin
                pend_v <= 1'b0;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset || !Halt) begin
            fc    <= 8'd0;
            phase <= 1'b0;
        end else if (wrap) begin
            if (fc >= FC_MAX) begin
                fc    <= 8'd0;
                phase <= ~phase;
            end else begin
                fc <= fc + 8'd1;
            end
        end
    end

    // Digit i is a leading zero when nibbles i..7 are all zero; digit 0 never is.
    always_comb begin
        blank_mask = 8'h00;
        for (int i = 1; i < 8; i++) begin
            blank_mask[i] = ((shown >> (4 * i)) == 32'd0);
        end
    end

    always_comb begin
        nib      = shown[{dig, 2'b00} +: 4];
        blank    = LZB && blank_mask[dig];
        an_next  = blank ? 8'hFF : ~(8'd1 << dig);
        seg_next = blank ? 7'h7F : hex_to_seg(nib);
        dp_next  = !((dig == 3'd0) && Halt && phase);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            AN    <= 8'hFF;
            SEG   <= 7'h7F;
            DP    <= 1'b1;
            Frame <= 1'b0;
        end else begin
            AN    <= an_next;
            SEG   <= seg_next;
            DP    <= dp_next;
            Frame <= wrap;
        end
    end

endmodule

// File: tb/tb_seg_display_scan.sv
// Directed bench for seg_display_scan with CLK_DIV = 4 (32-cycle frames)
// and BLINK_FRAMES = 2; expected segment patterns are hand-computed.
module tb_seg_display_scan;

    logic        Clock;
    logic        Reset;
    logic        Load;
    logic [31:0] Data;
    logic        LZB;
    logic        Halt;
    logic [7:0]  AN;
    logic [6:0]  SEG;
    logic        DP;
    logic        Frame;

    int errors = 0;
    int checks = 0;

    seg_display_scan #(
        .CLK_DIV(4),
        .BLINK_FRAMES(2)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .Load(Load),
        .Data(Data),
        .LZB(LZB),
        .Halt(Halt),
        .AN(AN),
        .SEG(SEG),
        .DP(DP),
        .Frame(Frame)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called right after a wrap-tick edge; checks the first cycle of each digit slot.
    task automatic check_frame(input string tag, input logic [55:0] segs, input logic [7:0] lit);
        logic [7:0] exp_an;
        for (int d = 0; d < 8; d++) begin
            step(1);
            exp_an = lit[d] ? ~(8'd1 << d) : 8'hFF;
            check($sformatf("%s_an%0d", tag, d), AN, exp_an);
            check($sformatf("%s_seg%0d", tag, d), SEG, segs[7*d +: 7]);
            step(3);
        end
    endtask

    logic [7:0] exp_an_k;
    logic       exp_frame_k;
    logic [5:0] dp_table;

    initial begin
        Reset = 1'b1;
        Load  = 1'b0;
        Data  = 32'd0;
        LZB   = 1'b0;
        Halt  = 1'b0;

        step(3);
        check("rst_an", AN, 8'hFF);
        check("rst_seg", SEG, 7'h7F);
        check("rst_dp", DP, 1'b1);
        check("rst_frame", Frame, 1'b0);

        Reset = 1'b0;
        step(1);
        check("first_an", AN, 8'hFE);
        check("first_seg", SEG, 7'h40);
        check("first_dp", DP, 1'b1);

        // Edges 2..64 after reset release: digit slot and Frame pulse cadence
        for (int k = 2; k <= 64; k++) begin
            step(1);
            exp_an_k    = ~(8'd1 << (((k - 1) / 4) % 8));
            exp_frame_k = ((k % 32) == 0);
            check($sformatf("scan_an_k%0d", k), AN, exp_an_k);
            check($sformatf("scan_frame_k%0d", k), Frame, exp_frame_k);
        end

        // Mid-frame load holds off until the wrap
        step(6);
        Load = 1'b1; Data = 32'h89ABCDEF;
        step(1);
        Load = 1'b0;
        step(1);
        check("mid_hold_an", AN, 8'hFD);
        check("mid_hold_seg", SEG, 7'h40);
        step(24);
        check("mid_hold_last_an", AN, 8'h7F);
        check("mid_hold_last_seg", SEG, 7'h40);
        check_frame("hex", {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}, 8'hFF);

        // Load on the wrap-tick cycle with nothing pending: one frame late
        step(31);
        Load = 1'b1; Data = 32'h12345678;
        step(1);
        Load = 1'b0;
        check_frame("wrapld_old", {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}, 8'hFF);
        check_frame("wrapld_new", {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}, 8'hFF);

        // Pending value present when a new Load hits the wrap tick
        step(10);
        Load = 1'b1; Data = 32'h11111111;
        step(1);
        Load = 1'b0;
        step(20);
        Load = 1'b1; Data = 32'h2468ACE0;
        step(1);
        Load = 1'b0;
        check_frame("dbl_first", {7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79}, 8'hFF);
        check_frame("dbl_second", {7'h24, 7'h19, 7'h02, 7'h00, 7'h08, 7'h46, 7'h06, 7'h40}, 8'hFF);

        // Leading-zero blanking
        Load = 1'b1; Data = 32'h00000A50;
        step(1);
        Load = 1'b0;
        step(31);
        LZB = 1'b1;
        check_frame("lzb_a50", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h12, 7'h40}, 8'h07);
        Load = 1'b1; Data = 32'h00000000;
        step(1);
        Load = 1'b0;
        step(31);
        check_frame("lzb_zero", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}, 8'h01);
        LZB = 1'b0;

        // Halt blink: DP low in digit 0 on frames 2,3 of each group of four
        Halt = 1'b1;
        dp_table = 6'b110011;
        for (int f = 0; f < 6; f++) begin
            step(1);
            check($sformatf("blink_dp_f%0d_start", f), DP, dp_table[f]);
            step(3);
            check($sformatf("blink_dp_f%0d_end", f), DP, dp_table[f]);
            step(1);
            check($sformatf("blink_dp_f%0d_dig1", f), DP, 1'b1);
            step(27);
        end
        step(1);
        check("blink_dp_f6", DP, 1'b0);
        Halt = 1'b0;
        step(1);
        check("halt_off_dp", DP, 1'b1);
        Halt = 1'b1;
        step(31);
        check("halt_restart_dp", DP, 1'b1);

        // Reset with a pending value mid-frame
        Load = 1'b1; Data = 32'h77777777;
        step(1);
        Load = 1'b0;
        step(30);
        Load = 1'b1; Data = 32'h55555555;
        step(1);
        Load = 1'b0;
        Halt = 1'b0;
        step(5);
        Reset = 1'b1;
        step(1);
        check("mid_rst_an", AN, 8'hFF);
        check("mid_rst_seg", SEG, 7'h7F);
        check("mid_rst_dp", DP, 1'b1);
        check("mid_rst_frame", Frame, 1'b0);
        Reset = 1'b0;
        step(1);
        check("post_rst_an", AN, 8'hFE);
        check("post_rst_seg", SEG, 7'h40);
        step(31);
        check_frame("post_rst", {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, 8'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_display_scan.md
# seg_display_scan

Drives the board's 8-digit multiplexed seven-segment display from the 32-bit syscall display value latched by the writeback stage. Accepts a one-cycle load strobe, double-buffers the value so updates take effect only at a scan-frame boundary, and time-multiplexes the eight hex digits with optional leading-zero blanking. Sits between the CPU core and the top-level pins, next to the program-halt indicator.

## Interface

- CLK_DIV, 100000: clock cycles per digit slot; 2..2^20.
- BLINK_FRAMES, 64: scan frames per halt-blink phase; 1..255.

- Clock  in  1  system clock; all state on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Load  in  1  one-cycle strobe: capture Data into the pending buffer.
- Data  in  32  value to display; nibble i is shown on digit i (digit 0 rightmost).
- LZB  in  1  leading-zero blanking enable; sampled every cycle.
- Halt  in  1  CPU halted; high blinks the DP of digit 0.
- AN  out  8  digit enables, active-low, one-hot-low or all high.
- SEG  out  7  segments a..g on bits 0..6, active-low.
- DP  out  1  decimal point, active-low.
- Frame  out  1  one-cycle pulse on every digit 7 -> 0 wrap.

## Operation

- Divider: div counts 0..CLK_DIV-1, wraps to 0; tick asserted when div == CLK_DIV-1.
- Digit index dig (3 bits) increments on tick; 7 -> 0 is a wrap.
- Pending buffer: Load sets pend <= Data, pend_v <= 1. Back-to-back Loads: last one wins.
- Shown value: on a wrap tick, if pend_v then shown <= pend, pend_v <= 0. Load in the same cycle as a wrap tick: shown takes the previous pend (if pend_v), pend <= Data, pend_v stays 1. Load with pend_v = 0 on a wrap tick does not reach shown that frame.
- Frame = 1 for exactly the cycle following the wrap tick.
- Segment decode, active-low hex: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
- Blanking: when LZB = 1, digit i (i >= 1) is blank if shown nibbles i..7 are all zero; blank digit drives AN all high, SEG = 7F. Digit 0 is never blanked (value 0 shows "0").
- Blink: frame counter fc counts wraps 0..BLINK_FRAMES-1; on reaching the limit, phase toggles and fc <= 0. While Halt = 0, fc and phase are held at 0.
- DP = 0 only when dig == 0 and Halt = 1 and phase = 1; otherwise 1.

## Timing

- Reset values: div 0, dig 0, pend 0, pend_v 0, shown 0, fc 0, phase 0, AN FF, SEG 7F, DP 1, Frame 0.
- AN, SEG, DP, Frame are registered: they reflect dig, shown, LZB, Halt, phase with exactly one cycle of latency.
- First cycle after Reset deasserts: AN = FE, SEG = 40, DP = 1.
- Each digit visible for CLK_DIV cycles; full frame 8*CLK_DIV cycles.
- Load-to-display latency: from the Load cycle to the first wrap tick, plus 1 cycle; worst case 8*CLK_DIV + 1.
- Reset mid-frame or with pend_v = 1: everything returns to reset values next cycle; pending data discarded.
- Halt deassert: DP returns to 1 within one cycle; blink restarts with phase 0.

## Test plan

- Reset, CLK_DIV = 4: hold Reset 3 cycles -> AN FF, SEG 7F, DP 1; next cycle AN FE, SEG 40; AN advances FE, FD, FB ... 7F every 4 cycles, Frame pulses every 32 cycles.
- Load Data = 0x89ABCDEF mid-frame -> shown unchanged until wrap; following frame SEG per digit 0..7 = 0E, 06, 21, 46, 03, 08, 10, 00.
- Load on exactly the wrap-tick cycle with pend_v = 0 -> value appears one frame later; with an earlier pending 0x11111111, that value shows first, then the new one.
- LZB = 1, Data = 0x00000A50 -> digits 0..2 show 40, 12, 08; digits 3..7 AN all high, SEG 7F; Data = 0 -> only digit 0 lit with 40.
- Halt = 1, BLINK_FRAMES = 2 -> DP low during digit 0 slot for frames 2-3, high for 0-1, repeating; Halt = 0 -> DP 1 next cycle.
- Reset asserted with pend_v = 1 mid-frame -> pending dropped; after next wrap shown stays 0.
